// File: rtl/scoreboard_scan_if.sv
// Bus bundle between the score-RAM scanner and its environment: RAM read port,
// scan control handshake and the three leaderboard slots.
interface scoreboard_scan_if;
    logic        start;
    logic [15:0] ram_data;
    logic [15:0] address;
    logic        wren;
    logic        scan_active;
    logic        busy;
    logic        done;
    logic [31:0] rank1;
    logic [31:0] rank2;
    logic [31:0] rank3;

    // The scanner masters the RAM address bus and publishes the results.
    modport master (
        input  start, ram_data,
        output address, wren, scan_active, busy, done, rank1, rank2, rank3
    );

    modport slave (
        output start, ram_data,
        input  address, wren, scan_active, busy, done, rank1, rank2, rank3
    );
endinterface

// File: rtl/scoreboard_scan.sv
// Walks the score RAM once per start pulse and keeps a registered top-3
// leaderboard of {user_id, score}; zero scores are treated as empty entries.
module scoreboard_scan #(
    parameter int N_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    scoreboard_scan_if.master bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [15:0] user_id;
        logic [15:0] score;
    } entry_t;

    localparam logic [15:0] LAST_ADDR = 16'(N_ENTRIES - 1);

    state_t      state;
    logic [15:0] address;
    logic        scan_active;
    logic        busy;
    logic        done;
    logic        rd_valid;   // ram_data this cycle answers the address of the previous cycle
    logic [15:0] cand_id;    // address that produced the current ram_data
    entry_t      r1, r2, r3;
    entry_t      r1_nx, r2_nx, r3_nx;
    entry_t      cand;

    // Insertion into the first slot whose score is strictly smaller; equal
    // scores never displace, so the earlier user id keeps the better rank.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cand  = '{user_id: cand_id, score: bus.ram_data};
        r1_nx = r1;
        r2_nx = r2;
        r3_nx = r3;
        if (rd_valid && cand.score != 16'd0) begin
            if (r1.score < cand.score) begin
                r3_nx = r2;
                r2_nx = r1;
                r1_nx = cand;
            end else if (r2.score < cand.score) begin
                r3_nx = r2;
                r2_nx = cand;
            end else if (r3.score < cand.score) begin
                r3_nx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state       <= IDLE;
            address     <= '0;
            scan_active <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_valid    <= 1'b0;
            cand_id     <= '0;
            r1          <= '0;
            r2          <= '0;
            r3          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= SCAN;
                        address     <= '0;
                        busy        <= 1'b1;
                        scan_active <= 1'b1;
                        r1          <= '0;
                        r2          <= '0;
                        r3          <= '0;
                    end
                end
                SCAN: begin
                    rd_valid <= 1'b1;
                    cand_id  <= address;
                    r1       <= r1_nx;
                    r2       <= r2_nx;
                    r3       <= r3_nx;
                    if (address == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        address <= address + 16'd1;
                    end
                end
                DRAIN: begin
                    // Last word is ranked here; results are final from the next cycle.
                    rd_valid    <= 1'b0;
                    r1          <= r1_nx;
                    r2          <= r2_nx;
                    r3          <= r3_nx;
                    address     <= '0;
                    busy        <= 1'b0;
                    scan_active <= 1'b0;
                    done        <= 1'b1;
                    state       <= FINISH;
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.address     = address;
    assign bus.wren        = 1'b0;
    assign bus.scan_active = scan_active;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.rank1       = r1;
    assign bus.rank2       = r2;
    assign bus.rank3       = r3;
endmodule

// File: tb/tb_scoreboard_scan.sv
// Directed bench for scoreboard_scan: a synchronous RAM model, a table of RAM
// images with hand-computed leaderboards, and sequences for busy-start, held start and reset.
module tb_scoreboard_scan;
    localparam int N = 16;

    typedef struct {
        string            name;
        logic [3:0][15:0] addr;
        logic [3:0][15:0] val;
        logic [31:0]      e1;
        logic [31:0]      e2;
        logic [31:0]      e3;
    } vec_t;

    logic clk;
    logic rst;
    logic [15:0] mem [N];
    int   n_checks;
    int   n_fail;
    vec_t vecs [4];

    scoreboard_scan_if bus ();

    scoreboard_scan #(.N_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle of latency.
    always @(posedge clk) bus.ram_data <= mem[bus.address[3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < N; i++) mem[i] = 16'd0;
        for (int j = 0; j < 4; j++) mem[v.addr[j][3:0]] = v.val[j];
    endtask

    // Pulses start, then observes cycles T+1 .. T+45 at the falling edge.
    task automatic run_scan(input int extra_at, input bit hold,
                            output int done_at, output int done2_at,
                            output int busy_cnt, output int done_cnt,
                            output logic [31:0] r_start);
        bit wren_seen;
        bit addr_bad;
        wren_seen = 1'b0;
        addr_bad  = 1'b0;
        done_at   = -1;
        done2_at  = -1;
        busy_cnt  = 0;
        done_cnt  = 0;
        r_start   = '1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 45; k++) begin
            bus.start = hold || (k == extra_at);
            if (k == 1) r_start = bus.rank1 | bus.rank2 | bus.rank3;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
                else if (done2_at < 0) done2_at = k;
            end
            if (bus.wren) wren_seen = 1'b1;
            if (!bus.scan_active && bus.address != 16'd0) addr_bad = 1'b1;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("wren_never_high", 32'(wren_seen), 32'd0);
        check("address_zero_when_idle", 32'(addr_bad), 32'd0);
    endtask

    task automatic check_vec(input vec_t v, input int extra_at);
        int done_at, done2_at, busy_cnt, done_cnt;
        logic [31:0] r_start;
        load_mem(v);
        run_scan(extra_at, 1'b0, done_at, done2_at, busy_cnt, done_cnt, r_start);
        check({v.name, " done_latency"}, 32'(done_at), 32'd18);
        check({v.name, " done_count"}, 32'(done_cnt), 32'd1);
        check({v.name, " busy_cycles"}, 32'(busy_cnt), 32'd17);
        check({v.name, " ranks_cleared_at_start"}, r_start, 32'd0);
        check({v.name, " rank1"}, bus.rank1, v.e1);
        check({v.name, " rank2"}, bus.rank2, v.e2);
        check({v.name, " rank3"}, bus.rank3, v.e3);
    endtask

    initial begin
        int done_at, done2_at, busy_cnt, done_cnt;
        bit done_seen;
        logic [31:0] r_start;
        n_checks = 0;
        n_fail   = 0;

        vecs[0].name = "all_zero";
        vecs[0].addr = {16'd0, 16'd0, 16'd0, 16'd0};
        vecs[0].val  = {16'd0, 16'd0, 16'd0, 16'd0};
        vecs[0].e1 = 32'h0; vecs[0].e2 = 32'h0; vecs[0].e3 = 32'h0;

        vecs[1].name = "scores";
        vecs[1].addr = {16'd12, 16'd9, 16'd7, 16'd3};
        vecs[1].val  = {16'd175, 16'd50, 16'd250, 16'd100};
        vecs[1].e1 = 32'h0007_00FA; vecs[1].e2 = 32'h000C_00AF; vecs[1].e3 = 32'h0003_0064;

        vecs[2].name = "ties";
        vecs[2].addr = {16'd10, 16'd8, 16'd5, 16'd2};
        vecs[2].val  = {16'd600, 16'd500, 16'd500, 16'd500};
        vecs[2].e1 = 32'h000A_0258; vecs[2].e2 = 32'h0002_01F4; vecs[2].e3 = 32'h0005_01F4;

        vecs[3].name = "last_only";
        vecs[3].addr = {16'd0, 16'd0, 16'd0, 16'd15};
        vecs[3].val  = {16'd0, 16'd0, 16'd0, 16'd1};
        vecs[3].e1 = 32'h000F_0001; vecs[3].e2 = 32'h0; vecs[3].e3 = 32'h0;

        for (int i = 0; i < N; i++) mem[i] = 16'd0;
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {16'd0, bus.address, 12'd0, bus.wren, bus.scan_active, bus.busy, bus.done}, 32'd0);
        check("reset_rank1", bus.rank1, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) check_vec(vecs[i], 0);

        // Start while busy is ignored; the rerun also proves old ranks are flushed.
        check_vec(vecs[1], 5);

        // Start held high: back-to-back scans separated by one IDLE cycle.
        load_mem(vecs[2]);
        run_scan(0, 1'b1, done_at, done2_at, busy_cnt, done_cnt, r_start);
        check("held_start first_done", 32'(done_at), 32'd18);
        check("held_start second_done", 32'(done2_at), 32'd37);
        repeat (25) @(negedge clk);

        // Reset at T+8 mid-scan.
        load_mem(vecs[1]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midscan_reset_ctrl", {16'd0, bus.address, 12'd0, bus.wren, bus.scan_active, bus.busy, bus.done}, 32'd0);
        check("midscan_reset_rank1", bus.rank1, 32'd0);
        check("midscan_reset_rank2", bus.rank2, 32'd0);
        check("midscan_reset_rank3", bus.rank3, 32'd0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        check("midscan_reset_no_done", 32'(done_seen), 32'd0);
        check_vec(vecs[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/scoreboard_scan.md
# scoreboard_scan

Read-side companion to the score-recording logic: scans the score RAM that the scoreboard writer fills and builds a top-3 leaderboard. The RAM holds one 16-bit score per user, addressed by user id. On a start pulse the block walks addresses 0..N_ENTRIES-1 with one read per cycle and ranks the non-zero scores. It presents {user_id, score} for ranks 1-3 to the display path.

## Interface
- N_ENTRIES, default 16: number of RAM words scanned, addresses 0..N_ENTRIES-1, range 2..65536.
- clk  in  1: single clock, all logic on rising edge.
- rst  in  1: asynchronous, active-low reset.
- start  in  1: one-cycle scan request, sampled only in IDLE.
- ram_data  in  16: RAM read data, valid the cycle after the address is driven (synchronous RAM, 1-cycle latency).
- address  out  16: RAM read address.
- wren  out  1: RAM write enable, constant 0.
- scan_active  out  1: high while the block owns the RAM address bus; used as the bus-mux select.
- busy  out  1: scan in progress.
- done  out  1: one-cycle pulse when results are final.
- rank1, rank2, rank3  out  32 each: {user_id[31:16], score[15:0]}; 32'h0 means the slot is empty.

## Operation
- States: IDLE, SCAN, DRAIN, FINISH.
- IDLE: start=1 -> SCAN. Clear rank1-3 to 0 on the transition. Set address=0, busy=1, scan_active=1.
- SCAN: address increments by 1 each cycle. At address N_ENTRIES-1 -> DRAIN; address holds at N_ENTRIES-1.
- Comparator operates every cycle whose read data is valid, i.e. the cycle after each address is issued. A delayed copy of the address acts as the candidate user_id.
- DRAIN: processes the final word, then -> FINISH.
- FINISH: done=1, busy=0, scan_active=0 for one cycle, then -> IDLE.
- Ranking: the candidate score s inserts into the first rank whose score is strictly less than s. Lower ranks shift down one place and the old rank3 is discarded.
- Score 0 means no entry and is never inserted.
- Ties: the strictly-less rule means an earlier (lower) user_id keeps the better rank.
- Comparisons are unsigned 16-bit. user_id is the 16-bit address, zero-extended.
- start in any state other than IDLE is ignored. It is not queued.
- rank1-3 hold their values after done until the next accepted start.
- address is 0 whenever scan_active=0.

## Timing
- Reset values: address=0, wren=0, scan_active=0, busy=0, done=0, rank1-3=0, state IDLE.
- Reset mid-scan aborts immediately and drives every output to its reset value. No done pulse is produced.
- Latency, with start sampled high at edge T:
  - Address k is driven during cycle T+1+k.
  - Its data is ranked at the edge ending cycle T+2+k.
  - done is high in cycle T+N_ENTRIES+2.
  - Total busy cycles: N_ENTRIES+1.
- rank outputs are registered. They may change during busy and are guaranteed final when done=1.
- start held high continuously: a new scan begins in the cycle after FINISH, one IDLE cycle later.

## Test plan
- RAM all zero, N_ENTRIES=16, start pulse -> done exactly 18 cycles after start; rank1-3=0; wren never 1.
- Scores at addr 3=100, 7=250, 9=50, 12=175, rest 0 -> rank1=32'h0007_00FA, rank2=32'h000C_00AF, rank3=32'h0003_0064.
- Tie: addr 2=500, addr 5=500, addr 8=500, addr 10=600 -> rank1={10,600}, rank2={2,500}, rank3={5,500}.
- Only addr 15=1 non-zero -> rank1=32'h000F_0001, rank2=rank3=0. Confirms the last word is processed via DRAIN.
- Second start pulse while busy (at T+5) -> ignored, done pulses once at T+18. Rerun with new RAM contents -> ranks cleared at start and replaced, no stale entries.
- rst low at T+8 mid-scan -> all outputs 0 immediately, no done pulse. After release, start -> full correct scan.
